// File: rtl/instr_encoder.sv
// instr_encoder: packs RV64 I/S/B fields into 32-bit words behind an output FIFO; define IMM_RANGE_CHECK_EN to flag out-of-range immediates
module instr_encoder #(
    parameter int DEPTH   = 2,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [6:0]         in_opcode,
    input  logic [4:0]         in_rd,
    input  logic [4:0]         in_rs1,
    input  logic [4:0]         in_rs2,
    input  logic [2:0]         in_funct3,
    input  logic [63:0]        in_imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic               out_err,
    output logic               err_sticky,
    input  logic               clr_err,
    output logic [COUNT_W-1:0] enc_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    logic [31:0]        mem_q [DEPTH];
    logic [DEPTH-1:0]   err_q;
    logic [AW-1:0]      wr_q, rd_q;
    logic [AW:0]        cnt_q, cnt_d;
    logic               sticky_q, sticky_d;
    logic [COUNT_W-1:0] enc_q;
    logic               push, pop, is_i, is_s, is_b, range_err, enc_err;
    logic [31:0]        enc;
    assign is_i = in_opcode == 7'b0010011 || in_opcode == 7'b0000011;
    assign is_s = in_opcode == 7'b0100011;
    assign is_b = in_opcode == 7'b1100011;
`ifdef IMM_RANGE_CHECK_EN
    assign range_err = in_imm[63:11] != {53{in_imm[11]}};
`else
    logic unused_imm_hi;
    assign unused_imm_hi = ^in_imm[63:12];
    assign range_err = 1'b0;
`endif
    always_comb begin
        enc = is_i ? {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode} :
              is_s ? {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode} :
              is_b ? {in_imm[11], in_imm[9:4], in_rs2, in_rs1, in_funct3, in_imm[3:0], in_imm[10], in_opcode} :
                     32'h0000_0013;
        enc_err = !(is_i || is_s || is_b) || range_err;
    end
    assign in_ready   = cnt_q != FULL;
    assign out_valid  = cnt_q != '0;
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign out_instr  = out_valid ? mem_q[rd_q] : 32'h0;
    assign out_err    = out_valid && err_q[rd_q];
    assign err_sticky = sticky_q;
    assign enc_count  = enc_q;
    always_comb begin
        cnt_d    = cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);
        sticky_d = (push && enc_err) || (sticky_q && !clr_err);
    end
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= enc;
            err_q[wr_q] <= enc_err;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            enc_q    <= '0;
        end else begin
            wr_q     <= push ? wr_q + 1'b1 : wr_q;
            rd_q     <= pop ? rd_q + 1'b1 : rd_q;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            enc_q    <= enc_q + COUNT_W'(push);
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed scoreboard bench for instr_encoder
module tb_instr_encoder;
    logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0, clr_err = 0;
    logic [6:0]  in_opcode = 0;
    logic [4:0]  in_rd = 0, in_rs1 = 0, in_rs2 = 0;
    logic [2:0]  in_funct3 = 0;
    logic [63:0] in_imm = 0;
    logic        in_ready, out_valid, out_err, err_sticky;
    logic [31:0] out_instr, last_instr = 0;
    logic [15:0] enc_count;
    logic [32:0] sb[$];
    int checks = 0, errors = 0;
`ifdef IMM_RANGE_CHECK_EN
    localparam bit RANGE_ERR = 1'b1;
`else
    localparam bit RANGE_ERR = 1'b0;
`endif

    instr_encoder #(.DEPTH(2), .COUNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_imm(in_imm), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err),
        .err_sticky(err_sticky), .clr_err(clr_err), .enc_count(enc_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] imm_gen_b(input logic [31:0] i);
        return {{52{i[31]}}, i[31], i[7], i[30:25], i[11:8]};
    endfunction

    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [63:0] imm,
                        input logic [31:0] ei, input logic ee);
        int n = 0;
        in_valid = 1; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_imm = imm;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready %b expected 1 within 50 cycles", in_ready);
        end else sb.push_back({ee, ei});
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got %b_%h expected no output", out_err, out_instr);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                if ({out_err, out_instr} !== e) begin
                    errors++;
                    $display("FAIL scoreboard: got err=%b instr=%h expected err=%b instr=%h",
                             out_err, out_instr, e[32], e[31:0]);
                end
                last_instr = out_instr;
            end
        end
    end

    initial begin
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_err_sticky", err_sticky, 0);
        chk("rst_enc_count", enc_count, 0);
        do_reset();
        out_ready = 1;
        send(7'b0010011, 5, 6, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFF30293, 0);
        chk("latency_valid", out_valid, 1);
        send(7'b0100011, 0, 2, 7, 3, 64'd8, 32'h00713423, 0);
        send(7'b1100011, 0, 1, 2, 0, -64'sd2, 32'hFE208EE3, 0);
        repeat (2) @(posedge clk);
        #1 chk("beq_imm_gen", imm_gen_b(last_instr), -64'sd2);
        chk("drain1", sb.size(), 0);
        chk("count3", enc_count, 3);
        do_reset();
        out_ready = 0;
        send(7'b0010011, 1, 0, 0, 0, 64'd1, 32'h00100093, 0);
        send(7'b0010011, 2, 0, 0, 0, 64'd2, 32'h00200113, 0);
        chk("full_in_ready", in_ready, 0);
        fork
            send(7'b0010011, 3, 0, 0, 0, 64'd3, 32'h00300193, 0);
            begin
                repeat (3) @(posedge clk);
                #1 chk("held_in_ready", in_ready, 0);
                chk("held_count", enc_count, 2);
                chk("head_stable", out_instr, 32'h00100093);
                out_ready = 1;
            end
        join
        repeat (4) @(posedge clk);
        #1 chk("bp_drain", sb.size(), 0);
        chk("bp_count", enc_count, 3);
        send(7'b0110011, 1, 2, 3, 0, 64'd0, 32'h00000013, 1);
        chk("err_sticky_set", err_sticky, 1);
        clr_err = 1;
        @(posedge clk);
        #1 clr_err = 0;
        chk("err_sticky_clr", err_sticky, 0);
        clr_err = 1;
        send(7'b1111111, 0, 0, 0, 0, 64'd0, 32'h00000013, 1);
        clr_err = 0;
        chk("set_wins", err_sticky, 1);
        clr_err = 1;
        @(posedge clk);
        #1 clr_err = 0;
        send(7'b0010011, 1, 0, 0, 0, 64'd2048, 32'h80000093, RANGE_ERR);
        send(7'b0000011, 1, 0, 0, 0, -64'sd2048, 32'h80000083, 0);
        repeat (2) @(posedge clk);
        #1 chk("range_sticky", err_sticky, RANGE_ERR);
        out_ready = 0;
        send(7'b0010011, 4, 0, 0, 0, 64'd4, 32'h00400213, 0);
        send(7'b0010011, 5, 0, 0, 0, 64'd5, 32'h00500293, 0);
        #2 rst = 1;
        #1 chk("async_out_valid", out_valid, 0);
        chk("async_in_ready", in_ready, 1);
        chk("async_enc_count", enc_count, 0);
        sb.delete();
        do_reset();
        chk("post_rst_valid", out_valid, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV64 instruction encoder: the inverse of the immediate generator in the decode path. Accepts opcode, register, funct3 and a 64-bit immediate over a valid/ready handshake, packs them into a 32-bit instruction word, and buffers results in a small output FIFO. It is used by the instruction-memory loader and by the round-trip self-checking bench. For any supported opcode, `imm_gen(out_instr) == in_imm` whenever `in_imm` is in range.

## Interface
- `DEPTH`, 2, output FIFO entries; power of two, ≥2.
- `COUNT_W`, 16, width of `enc_count`.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input fields valid.
- `in_ready`  out  1  encoder can accept.
- `in_opcode`  in  7  opcode field.
- `in_rd`  in  5  destination register.
- `in_rs1`  in  5  source register 1.
- `in_rs2`  in  5  source register 2.
- `in_funct3`  in  3  funct3 field.
- `in_imm`  in  64  sign-extended immediate, in imm_gen convention (B-type is the halfword offset, unshifted).
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer accepts head.
- `out_instr`  out  32  encoded instruction at head.
- `out_err`  out  1  error flag of head entry.
- `err_sticky`  out  1  set on any accepted errored entry.
- `clr_err`  in  1  synchronous clear of `err_sticky`.
- `enc_count`  out  COUNT_W  accepted-transfer counter, wraps.

## Operation
- Accept when `in_valid && in_ready`; encode combinationally and push {instr, err} into FIFO.
- Encoding by opcode:
  - 0010011 / 0000011 (I): {imm[11:0], rs1, funct3, rd, opcode}.
  - 0100011 (S): {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - 1100011 (B): {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode}.
  - Any other opcode: instr = 32'h00000013 (nop); err = 1.
- Fields not used by a format (e.g. rs2 for I-type, rd for S/B) are ignored.
- Pop when `out_valid && out_ready`. Order is strictly FIFO.
- `in_ready = (count != DEPTH)`, from registered state only; no combinational path from `out_ready`.
- Simultaneous push and pop when not full and not empty: count unchanged.
- `err_sticky` is set when an entry with err = 1 is accepted. `clr_err` clears it; if set and clear happen in the same cycle, set wins.
- `enc_count` increments per accepted transfer and wraps from 2^COUNT_W−1 to 0.

## Timing
- Reset values: FIFO empty, `out_valid` 0, `in_ready` 1, `out_instr` 0, `out_err` 0, `err_sticky` 0, `enc_count` 0.
- Latency: a transfer accepted at edge N into an empty FIFO gives `out_valid` = 1 with data after edge N.
- Throughput: one per cycle when `out_ready` is held high.
- Full: `in_ready` = 0. A pop at edge N raises `in_ready` after edge N.
- Head data is stable while `out_valid && !out_ready`.
- Reset mid-operation: all buffered entries are discarded immediately (async); counters and flags return to their reset values.

## Configuration
- `IMM_RANGE_CHECK_EN` defined: for every supported opcode, err = 1 if `in_imm[63:11]` is not all equal to `in_imm[11]`. The instruction is still encoded from the low bits.
- Undefined: no range check. err comes only from an unsupported opcode, and out-of-range immediates are silently truncated.

## Test plan
- addi x5,x6,-1 (op 0010011, rd 5, rs1 6, f3 0, imm 64'hFFFF_FFFF_FFFF_FFFF) -> `out_instr` 0xFFF30293, `out_err` 0, one cycle after accept.
- sd x7,8(x2) (op 0100011, rs1 2, rs2 7, f3 3, imm 8) -> 0x00713423.
- beq x1,x2 (op 1100011, rs1 1, rs2 2, f3 0, imm −2) -> 0xFE208EE3; feeding it to imm_gen returns −2.
- Backpressure: hold `out_ready` = 0 and offer 3 transfers. `in_ready` drops after 2 accepts and the third is held. Release `out_ready`: all 3 drain in order and `enc_count` = 3.
- Errors:
  - op 0110011 -> instr 0x00000013, `out_err` 1, `err_sticky` 1.
  - `clr_err` pulse -> `err_sticky` 0.
  - I-type with imm 2048 -> `out_err` 1 with macro, 0 without; both give instr[31:20] = 0x800.
- Assert `rst` with 2 entries buffered -> `out_valid` 0, `in_ready` 1, `enc_count` 0 immediately, with no clock edge required.
